// File: rtl/wb_ext_io_pkg.sv
// rtl/wb_ext_io_pkg.sv - shared constants, register indices and bus structs for the external-IO responder
package wb_ext_io_pkg;

    localparam int WB_ADR_W = 30;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    localparam int REG_CTRL   = 0;
    localparam int REG_STATUS = 1;

    // The write counter always occupies the top register index.
    function automatic int reg_wcount(input int num_regs);
        return num_regs - 1;
    endfunction

    typedef struct packed {
        logic [WB_ADR_W-1:0] adr;
        logic [WB_DAT_W-1:0] dat;
        logic [WB_SEL_W-1:0] sel;
        logic                cyc;
        logic                stb;
        logic                we;
    } wb_req_t;

    typedef struct packed {
        logic [WB_DAT_W-1:0] dat;
        logic                ack;
        logic                stall;
    } wb_rsp_t;

endpackage

// File: rtl/wb_ack_pipe.sv
// rtl/wb_ack_pipe.sv - fixed-latency valid/data shift pipeline with synchronous flush
module wb_ack_pipe #(
    parameter int LATENCY = 3,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [LATENCY-1:0]             valid_q, valid_d;
    logic [LATENCY-1:0][DATA_W-1:0] data_q, data_d;

    // Shift every stage one step; flush drops all valid bits but keeps data.
    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        valid_d[0] = in_valid;
        data_d[0]  = in_data;
        for (int i = 1; i < LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    // Pipeline state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/wb_ext_io_responder.sv
// rtl/wb_ext_io_responder.sv - pipelined Wishbone slave backing the external-IO debug register bank
module wb_ext_io_responder
    import wb_ext_io_pkg::*;
#(
    parameter int NUM_REGS        = 16,
    parameter int ACK_LATENCY     = 3,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                system_clk,
    input  logic                rst,
    input  logic [WB_ADR_W-1:0] wb_adr,
    input  logic [WB_DAT_W-1:0] wb_dat_w,
    input  logic [WB_SEL_W-1:0] wb_sel,
    input  logic                wb_cyc,
    input  logic                wb_stb,
    input  logic                wb_we,
    output logic [WB_DAT_W-1:0] wb_dat_r,
    output logic                wb_ack,
    output logic                wb_stall,
    input  logic [WB_DAT_W-1:0] status_in,
    output logic [WB_DAT_W-1:0] ctrl_out
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(REG_CTRL);
    localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(REG_STATUS);
    localparam logic [IDX_W-1:0] IDX_WCOUNT = IDX_W'(reg_wcount(NUM_REGS));
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_OUTSTANDING);

    logic [WB_DAT_W-1:0] regs_q [NUM_REGS];
    logic [WB_DAT_W-1:0] regs_d [NUM_REGS];
    logic [31:0]         wcount_q, wcount_d;
    logic [CNT_W-1:0]    outst_q, outst_d;

    logic [IDX_W-1:0]    idx;
    logic                accept;
    logic                ack_now;
    logic [WB_DAT_W-1:0] rd_data;
    logic [WB_DAT_W-1:0] pipe_data;

    assign idx    = wb_adr[IDX_W-1:0];
    assign accept = wb_cyc & wb_stb & ~wb_stall;

    // A slot freed by this cycle's ack can be refilled in the same cycle.
    assign wb_stall = (outst_q == CNT_MAX) & ~ack_now;

    // Byte-wise writes to RW registers; RO indices ignore data but still count.
    always_comb begin
        regs_d   = regs_q;
        wcount_d = wcount_q;
        if (accept && wb_we) begin
            wcount_d = wcount_q + 32'd1;
            if (idx != IDX_STATUS && idx != IDX_WCOUNT) begin
                for (int b = 0; b < WB_SEL_W; b++) begin
                    if (wb_sel[b]) begin
                        regs_d[idx][8*b +: 8] = wb_dat_w[8*b +: 8];
                    end
                end
            end
        end
    end

    // Outstanding count; dropping wb_cyc abandons everything in flight.
    always_comb begin
        outst_d = outst_q;
        if (!wb_cyc) begin
            outst_d = '0;
        end else if (accept && !ack_now) begin
            outst_d = outst_q + CNT_W'(1);
        end else if (!accept && ack_now) begin
            outst_d = outst_q - CNT_W'(1);
        end
    end

    // Read data captured at acceptance; writes carry zero so their ack shows zero.
    always_comb begin
        rd_data = '0;
        if (!wb_we) begin
            if (idx == IDX_STATUS) begin
                rd_data = status_in;
            end else if (idx == IDX_WCOUNT) begin
                rd_data = wcount_q;
            end else begin
                rd_data = regs_q[idx];
            end
        end
    end

    // Register bank, write counter and outstanding count state.
    always_ff @(posedge system_clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wcount_q <= '0;
            outst_q  <= '0;
        end else begin
            regs_q   <= regs_d;
            wcount_q <= wcount_d;
            outst_q  <= outst_d;
        end
    end

    wb_ack_pipe #(
        .LATENCY (ACK_LATENCY),
        .DATA_W  (WB_DAT_W)
    ) u_ack_pipe (
        .clk       (system_clk),
        .rst       (rst),
        .flush     (~wb_cyc),
        .in_valid  (accept),
        .in_data   (rd_data),
        .out_valid (ack_now),
        .out_data  (pipe_data)
    );

    assign wb_ack   = ack_now;
    assign wb_dat_r = ack_now ? pipe_data : '0;
    assign ctrl_out = regs_q[IDX_CTRL];

endmodule

// File: tb/tb_wb_ext_io_responder.sv
// tb/tb_wb_ext_io_responder.sv - directed self-checking bench for wb_ext_io_responder
module tb_wb_ext_io_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] wb_adr;
    logic [31:0] wb_dat_w;
    logic [3:0]  wb_sel;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_dat_r;
    logic        wb_ack;
    logic        wb_stall;
    logic [31:0] status_in;
    logic [31:0] ctrl_out;

    int          checks = 0;
    int          errors = 0;
    int          ack_total = 0;
    logic [31:0] ctrl_seen;

    always #5 clk = ~clk;

    wb_ext_io_responder #(
        .NUM_REGS        (16),
        .ACK_LATENCY     (3),
        .MAX_OUTSTANDING (2)
    ) dut (
        .system_clk (clk),
        .rst        (rst),
        .wb_adr     (wb_adr),
        .wb_dat_w   (wb_dat_w),
        .wb_sel     (wb_sel),
        .wb_cyc     (wb_cyc),
        .wb_stb     (wb_stb),
        .wb_we      (wb_we),
        .wb_dat_r   (wb_dat_r),
        .wb_ack     (wb_ack),
        .wb_stall   (wb_stall),
        .status_in  (status_in),
        .ctrl_out   (ctrl_out)
    );

    always @(negedge clk) begin
        if (wb_ack === 1'b1) ack_total++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits for the next ack after an acceptance edge; lat counts cycles from that edge.
    task automatic wait_ack(output logic [31:0] rdata, output int lat);
        rdata = 'x;
        lat   = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) ctrl_seen = ctrl_out;
            if (wb_ack === 1'b1) begin
                rdata = wb_dat_r;
                lat   = c;
                break;
            end
        end
    endtask

    task automatic xfer(input logic we, input logic [29:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [31:0] st_after,
                        output logic [31:0] rdata, output int lat);
        int guard;
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
        wb_adr = adr; wb_dat_w = dat; wb_sel = sel;
        guard = 0;
        @(negedge clk);
        while (wb_stall === 1'b1 && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 20) chk("accept_timeout", {31'b0, wb_stall}, 32'd0);
        @(posedge clk); #1;
        wb_stb = 1'b0; wb_we = 1'b0;
        status_in = st_after;
        wait_ack(rdata, lat);
    endtask

    task automatic burst(input int n, input int rst_at, output int accepted);
        int acc;
        int a0;
        acc = 0;
        a0  = ack_total;
        for (int c = 0; c < n * 4 + 50; c++) begin
            @(posedge clk); #1;
            if (rst_at >= 0 && acc == rst_at) begin
                wb_stb = 1'b0; rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                break;
            end
            if (acc >= n && (ack_total - a0) >= n) break;
            wb_cyc = 1'b1; wb_we = 1'b1; wb_adr = 30'd5; wb_sel = 4'hF;
            wb_dat_w = 32'(acc); wb_stb = (acc < n);
            @(negedge clk);
            if (wb_stb && wb_stall === 1'b0) acc++;
        end
        wb_stb = 1'b0; wb_we = 1'b0;
        accepted = acc;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [29:0] b2b_adr [6];
        logic [31:0] b2b_exp [6];
        logic [31:0] rd;
        int          lat;
        int          idx, aidx, outm, maxout, a0, acc;
        logic        stall_exp;

        b2b_adr = '{30'd0, 30'd2, 30'd3, 30'd4, 30'd0, 30'd2};
        b2b_exp = '{32'hDEADBEEF, 32'hFF34FF78, 32'h33333333, 32'h44444444,
                    32'hDEADBEEF, 32'hFF34FF78};

        rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        wb_adr = '0; wb_dat_w = '0; wb_sel = '0; status_in = 32'h0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_ack", {31'b0, wb_ack}, 32'd0);
        chk("reset_dat_r", wb_dat_r, 32'd0);
        chk("reset_stall", {31'b0, wb_stall}, 32'd0);
        chk("reset_ctrl", ctrl_out, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single write to CTRL, then WCOUNT read.
        xfer(1'b1, 30'd0, 32'hDEADBEEF, 4'hF, 32'h0, rd, lat);
        chk("ctrl_next_cycle", ctrl_seen, 32'hDEADBEEF);
        chk("write_ack_latency", 32'(lat), 32'd3);
        chk("write_ack_data_zero", rd, 32'd0);
        xfer(1'b0, 30'd15, 32'h0, 4'hF, 32'h0, rd, lat);
        chk("wcount_one", rd, 32'd1);
        chk("read_ack_latency", 32'(lat), 32'd3);

        // Byte lanes.
        xfer(1'b1, 30'd2, 32'hFFFFFFFF, 4'hF, 32'h0, rd, lat);
        xfer(1'b1, 30'd2, 32'h12345678, 4'h5, 32'h0, rd, lat);
        xfer(1'b0, 30'd2, 32'h0, 4'hF, 32'h0, rd, lat);
        chk("byte_lanes", rd, 32'hFF34FF78);
        xfer(1'b1, 30'd3, 32'h33333333, 4'hF, 32'h0, rd, lat);
        xfer(1'b1, 30'd4, 32'h44444444, 4'hF, 32'h0, rd, lat);
        xfer(1'b0, 30'h3FFFFFF2, 32'h0, 4'hF, 32'h0, rd, lat);
        chk("upper_adr_alias", rd, 32'hFF34FF78);

        // Back-to-back reads against the outstanding limit.
        idx = 0; aidx = 0; outm = 0; maxout = 0;
        for (int c = 0; c < 40 && aidx < 6; c++) begin
            @(posedge clk); #1;
            wb_cyc = 1'b1; wb_we = 1'b0; wb_sel = 4'hF;
            wb_stb = (idx < 6);
            wb_adr = (idx < 6) ? b2b_adr[idx] : 30'd0;
            @(negedge clk);
            stall_exp = (outm == 2) && (wb_ack !== 1'b1);
            chk("b2b_stall", {31'b0, wb_stall}, {31'b0, stall_exp});
            if (c == 2) chk("b2b_stall_after_two", {31'b0, wb_stall}, 32'd1);
            if (wb_ack === 1'b1) begin
                chk("b2b_data", wb_dat_r, b2b_exp[aidx]);
                aidx++;
                outm--;
            end
            if (wb_stb && wb_stall === 1'b0) begin
                idx++;
                outm++;
            end
            if (outm > maxout) maxout = outm;
        end
        wb_stb = 1'b0;
        chk("b2b_ack_count", 32'(aidx), 32'd6);
        chk("b2b_max_outstanding", 32'(maxout), 32'd2);

        // STATUS sampled at acceptance; RO write leaves it alone but counts.
        status_in = 32'hA5A5A5A5;
        xfer(1'b0, 30'd1, 32'h0, 4'hF, 32'h0, rd, lat);
        chk("status_sampled_at_accept", rd, 32'hA5A5A5A5);
        xfer(1'b1, 30'd1, 32'h11111111, 4'hF, 32'h5A5A0000, rd, lat);
        chk("ro_write_acked", 32'(lat), 32'd3);
        xfer(1'b0, 30'd1, 32'h0, 4'hF, 32'h5A5A0000, rd, lat);
        chk("status_unchanged", rd, 32'h5A5A0000);
        xfer(1'b0, 30'd15, 32'h0, 4'hF, 32'h5A5A0000, rd, lat);
        chk("wcount_six", rd, 32'd6);

        // Abort with two reads in flight.
        @(posedge clk); #1;
        a0 = ack_total;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 30'd0;
        @(negedge clk);
        chk("abort_accept0", {31'b0, wb_stall}, 32'd0);
        @(posedge clk); #1;
        wb_adr = 30'd2;
        @(negedge clk);
        chk("abort_accept1", {31'b0, wb_stall}, 32'd0);
        @(posedge clk); #1;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge clk);
        chk("abort_no_ack_drop", {31'b0, wb_ack}, 32'd0);
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_adr = 30'd3;
        @(negedge clk);
        chk("abort_stall_clear", {31'b0, wb_stall}, 32'd0);
        chk("abort_flushed_ack", {31'b0, wb_ack}, 32'd0);
        @(posedge clk); #1;
        wb_stb = 1'b0;
        wait_ack(rd, lat);
        chk("abort_new_latency", 32'(lat), 32'd3);
        chk("abort_new_data", rd, 32'h33333333);
        repeat (5) @(posedge clk);
        #1;
        chk("abort_ack_count", 32'(ack_total - a0), 32'd1);

        // 300 writes through the pipeline, then a reset in mid-burst.
        a0 = ack_total;
        burst(300, -1, acc);
        chk("burst_accepts", 32'(acc), 32'd300);
        chk("burst_acks", 32'(ack_total - a0), 32'd300);
        xfer(1'b0, 30'd15, 32'h0, 4'hF, 32'h0, rd, lat);
        chk("wcount_306", rd, 32'd306);

        burst(40, 10, acc);
        a0 = ack_total;
        repeat (6) @(posedge clk);
        #1;
        chk("no_stale_acks", 32'(ack_total - a0), 32'd0);
        chk("reset_ctrl_cleared", ctrl_out, 32'd0);
        xfer(1'b0, 30'd15, 32'h0, 4'hF, 32'h0, rd, lat);
        chk("wcount_after_reset", rd, 32'd0);
        for (int i = 0; i < 5; i++) begin
            xfer(1'b1, 30'(6 + i), 32'(i), 4'hF, 32'h0, rd, lat);
        end
        xfer(1'b0, 30'd15, 32'h0, 4'hF, 32'h0, rd, lat);
        chk("wcount_five", rd, 32'd5);
        xfer(1'b0, 30'd9, 32'h0, 4'hF, 32'h0, rd, lat);
        chk("scratch_readback", rd, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
